user_move_ctrl: RTL and testbench

USER_MOVE_CTRL -- requirements
Module: user_move_ctrl

---
 rtl/user_move_if.sv | 25 ++
 rtl/user_move_ctrl.sv | 137 +++++++++++++
 tb/tb_user_move_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/user_move_if.sv
// Handshake bundle between the player movement controller and its
// input/plotter side: movement requests in, sprite pass control out.
interface user_move_if;
  logic       frame_tick;
  logic       move_left;
  logic       move_right;
  logic       draw_done;
  logic       draw_start;
  logic       erase;
  logic [8:0] x_pos;
  logic [7:0] y_pos;
  logic       busy;

  // Drives requests and plotter completion, observes the controller.
  modport master (
    output frame_tick, move_left, move_right, draw_done,
    input  draw_start, erase, x_pos, y_pos, busy
  );

  // The controller itself.
  modport slave (
    input  frame_tick, move_left, move_right, draw_done,
    output draw_start, erase, x_pos, y_pos, busy
  );
endinterface

// File: rtl/user_move_ctrl.sv
// Player sprite movement controller.
// Draws the sprite once after reset, then on each frame tick with a single
// direction held, erases the sprite at its old x, steps x with saturation
// at the screen edges, and redraws it. Only one plotter pass is ever
// outstanding. draw_start/erase/busy are registered, so each pulse
// appears in the cycle after its *_START state.
//
// state       | meaning
// INIT_START  | issue the first draw at X_INIT
// INIT_WAIT   | wait for the first draw to complete
// IDLE        | wait for a frame tick with a usable direction
// ERASE_START | issue an erase pass at the old x
// ERASE_WAIT  | erase pass in progress
// UPDATE      | step x toward the sampled direction, saturating
// DRAW_START  | issue a draw pass at the new x
// DRAW_WAIT   | draw pass in progress
module user_move_ctrl #(
  parameter logic [8:0] X_INIT = 9'd146,
  parameter logic [7:0] Y_USER = 8'd200,
  parameter logic [8:0] X_MIN  = 9'd0,
  parameter logic [8:0] X_MAX  = 9'd292,
  parameter logic [8:0] STEP   = 9'd2
) (
  input  logic        clk,
  input  logic        reset,
  user_move_if.slave  bus
);

  typedef enum logic [2:0] {
    INIT_START,
    INIT_WAIT,
    IDLE,
    ERASE_START,
    ERASE_WAIT,
    UPDATE,
    DRAW_START,
    DRAW_WAIT
  } state_t;

  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b01;

  state_t     state_q, state_d;
  logic [8:0] x_pos_q, x_pos_d;
  logic [1:0] dir_q, dir_d;
  logic       draw_start_q, draw_start_d;
  logic       erase_q, erase_d;
  logic       busy_q, busy_d;
  logic [1:0] dir_in;
  logic       move_ok;

  // Next-state and next-output logic for the whole controller.
  always_comb begin
    state_d      = state_q;
    x_pos_d      = x_pos_q;
    dir_d        = dir_q;
    erase_d      = erase_q;
    draw_start_d = 1'b0;
    dir_in       = {bus.move_left, bus.move_right};
    // A move is only worth a pass if the sprite is not already at that edge.
    move_ok      = ((dir_in == DIR_LEFT)  && (x_pos_q > X_MIN)) ||
                   ((dir_in == DIR_RIGHT) && (x_pos_q < X_MAX));

    case (state_q)
      INIT_START: begin
        draw_start_d = 1'b1;
        erase_d      = 1'b0;
        x_pos_d      = X_INIT;
        state_d      = INIT_WAIT;
      end
      INIT_WAIT: begin
        if (bus.draw_done) state_d = IDLE;
      end
      IDLE: begin
        if (bus.frame_tick) begin
          dir_d = dir_in;
          if (move_ok) state_d = ERASE_START;
        end
      end
      ERASE_START: begin
        draw_start_d = 1'b1;
        erase_d      = 1'b1;
        state_d      = ERASE_WAIT;
      end
      ERASE_WAIT: begin
        if (bus.draw_done) begin
          erase_d = 1'b0;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        if (dir_q == DIR_LEFT)
          x_pos_d = (x_pos_q < X_MIN + STEP) ? X_MIN : x_pos_q - STEP;
        else if (dir_q == DIR_RIGHT)
          x_pos_d = (x_pos_q > X_MAX - STEP) ? X_MAX : x_pos_q + STEP;
        state_d = DRAW_START;
      end
      DRAW_START: begin
        draw_start_d = 1'b1;
        erase_d      = 1'b0;
        state_d      = DRAW_WAIT;
      end
      DRAW_WAIT: begin
        if (bus.draw_done) state_d = IDLE;
      end
      default: state_d = INIT_START;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any pass and restarts the init draw.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= INIT_START;
      x_pos_q      <= X_INIT;
      dir_q        <= 2'b00;
      draw_start_q <= 1'b0;
      erase_q      <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      x_pos_q      <= x_pos_d;
      dir_q        <= dir_d;
      draw_start_q <= draw_start_d;
      erase_q      <= erase_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.draw_start = draw_start_q;
  assign bus.erase      = erase_q;
  assign bus.x_pos      = x_pos_q;
  assign bus.y_pos      = Y_USER;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_user_move_ctrl.sv
`timescale 1ns/1ps
module tb_user_move_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic       rst_v   [2];
  logic       tick_v  [2];
  logic       left_v  [2];
  logic       right_v [2];
  logic       spur_v  [2];
  logic       ds_v    [2];
  logic       er_v    [2];
  logic       busy_v  [2];
  logic       done_v  [2];
  logic [8:0] x_v     [2];
  logic [7:0] y_v     [2];
  int         lat     [2] = '{561, 561};
  int         npulse  [2] = '{0, 0};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Unit 0 uses the default X_INIT=146; unit 1 starts at x=1 to reach odd edge positions.
  for (genvar g = 0; g < 2; g++) begin : gu
    localparam logic [8:0] XI = (g == 0) ? 9'd146 : 9'd1;
    user_move_if ifc ();
    logic       resp_done;
    logic       prev_ds;
    logic [9:0] e;
    logic [9:0] exp_q [$];

    assign ifc.frame_tick = tick_v[g];
    assign ifc.move_left  = left_v[g];
    assign ifc.move_right = right_v[g];
    assign ifc.draw_done  = resp_done | spur_v[g];
    assign ds_v[g]   = ifc.draw_start;
    assign er_v[g]   = ifc.erase;
    assign busy_v[g] = ifc.busy;
    assign done_v[g] = ifc.draw_done;
    assign x_v[g]    = ifc.x_pos;
    assign y_v[g]    = ifc.y_pos;

    user_move_ctrl #(.X_INIT(XI)) dut (
      .clk   (clk),
      .reset (rst_v[g]),
      .bus   (ifc)
    );

    // Plotter model: answer each draw_start with draw_done lat cycles later; reset abandons it.
    initial begin
      resp_done = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        if (ifc.draw_start && !rst_v[g]) begin
          for (int k = 0; k < lat[g] - 1; k++) begin
            @(posedge clk);
            if (rst_v[g]) break;
          end
          if (!rst_v[g]) begin
            #1 resp_done = 1'b1;
            @(posedge clk);
            #1 resp_done = 1'b0;
          end
        end
      end
    end

    // Scoreboard monitor: every draw_start pulse is matched against the next expected pass.
    initial begin
      prev_ds = 1'b0;
      forever begin
        @(negedge clk);
        if (ds_v[g]) begin
          npulse[g]++;
          check($sformatf("u%0d_draw_start_back_to_back", g), int'(prev_ds), 0);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL u%0d_unexpected_pass: got erase=%0d x=%0d expected no pass",
                     g, er_v[g], x_v[g]);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("u%0d_pass_erase", g), int'(er_v[g]), int'(e[9]));
            check($sformatf("u%0d_pass_x", g), int'(x_v[g]), int'(e[8:0]));
          end
        end
        prev_ds = ds_v[g];
      end
    end
  end

  task automatic push(input int u, input logic er, input int x);
    logic [8:0] xx;
    xx = x[8:0];
    if (u == 0) gu[0].exp_q.push_back({er, xx});
    else        gu[1].exp_q.push_back({er, xx});
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic tick(input int u, input logic l, input logic r);
    left_v[u]  = l;
    right_v[u] = r;
    tick_v[u]  = 1'b1;
    cyc(1);
    tick_v[u]  = 1'b0;
  endtask

  task automatic wait_idle(input int u, input string name);
    for (int k = 0; k < 3000 && busy_v[u]; k++) cyc(1);
    if (busy_v[u]) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got busy=1 after 3000 cycles expected busy=0", name);
    end
  endtask

  int n0;
  int xm;

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst_v[u] = 1'b1; tick_v[u] = 1'b0; left_v[u] = 1'b0;
      right_v[u] = 1'b0; spur_v[u] = 1'b0;
    end
    cyc(2);
    check("rst_x", int'(x_v[0]), 146);
    check("rst_y", int'(y_v[0]), 200);
    check("rst_busy", int'(busy_v[0]), 1);
    check("rst_draw_start", int'(ds_v[0]), 0);
    check("rst_erase", int'(er_v[0]), 0);
    check("rst_x_u1", int'(x_v[1]), 1);

    // Initial draw, plotter answering 561 cycles after draw_start.
    push(0, 1'b0, 146);
    n0 = npulse[0];
    rst_v[0] = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (done_v[0]) break;
    end
    check("init_done_seen", int'(done_v[0]), 1);
    check("init_busy_at_done", int'(busy_v[0]), 1);
    @(negedge clk);
    check("init_busy_after_done", int'(busy_v[0]), 0);
    check("init_pulses", npulse[0] - n0, 1);
    check("init_x", int'(x_v[0]), 146);
    cyc(1);
    lat[0] = 20;

    // Move right from 146: erase at 146, draw at 148.
    n0 = npulse[0];
    push(0, 1'b1, 146); push(0, 1'b0, 148);
    tick(0, 1'b0, 1'b1);
    check("mv_right_busy", int'(busy_v[0]), 1);
    wait_idle(0, "mv_right");
    check("mv_right_x", int'(x_v[0]), 148);
    check("mv_right_pulses", npulse[0] - n0, 2);

    // Tick and direction change during ERASE_WAIT are ignored.
    n0 = npulse[0];
    push(0, 1'b1, 148); push(0, 1'b0, 146);
    tick(0, 1'b1, 1'b0);
    cyc(5);
    check("erase_wait_erase", int'(er_v[0]), 1);
    tick(0, 1'b0, 1'b1);
    wait_idle(0, "mv_left");
    check("mv_left_x", int'(x_v[0]), 146);
    check("mv_left_pulses", npulse[0] - n0, 2);

    // Spurious draw_done while idle.
    n0 = npulse[0];
    spur_v[0] = 1'b1;
    cyc(1);
    spur_v[0] = 1'b0;
    check("spur_busy", int'(busy_v[0]), 0);
    cyc(5);
    check("spur_pulses", npulse[0] - n0, 0);
    check("spur_x", int'(x_v[0]), 146);

    // Reach DRAW_WAIT at x=150, then reset mid-pass.
    push(0, 1'b1, 146); push(0, 1'b0, 148);
    tick(0, 1'b0, 1'b1);
    wait_idle(0, "mv_to_148");
    n0 = npulse[0];
    push(0, 1'b1, 148); push(0, 1'b0, 150);
    tick(0, 1'b0, 1'b1);
    for (int k = 0; k < 200 && npulse[0] < n0 + 2; k++) cyc(1);
    check("dw_pulses", npulse[0] - n0, 2);
    cyc(3);
    check("dw_busy", int'(busy_v[0]), 1);
    check("dw_x", int'(x_v[0]), 150);
    rst_v[0] = 1'b1;
    #1;
    check("midrst_x", int'(x_v[0]), 146);
    check("midrst_busy", int'(busy_v[0]), 1);
    check("midrst_draw_start", int'(ds_v[0]), 0);
    check("midrst_erase", int'(er_v[0]), 0);
    cyc(3);
    n0 = npulse[0];
    push(0, 1'b0, 146);
    rst_v[0] = 1'b0;
    wait_idle(0, "redo_init");
    check("redo_init_x", int'(x_v[0]), 146);
    check("redo_init_pulses", npulse[0] - n0, 1);

    // Unit 1: left edge from x=1.
    lat[1] = 3;
    n0 = npulse[1];
    push(1, 1'b0, 1);
    rst_v[1] = 1'b0;
    wait_idle(1, "u1_init");
    check("u1_init_x", int'(x_v[1]), 1);
    push(1, 1'b1, 1); push(1, 1'b0, 0);
    tick(1, 1'b1, 1'b0);
    wait_idle(1, "u1_left_sat");
    check("u1_left_sat_x", int'(x_v[1]), 0);
    check("u1_left_sat_pulses", npulse[1] - n0, 3);
    n0 = npulse[1];
    tick(1, 1'b1, 1'b0);
    check("u1_left_edge_busy", int'(busy_v[1]), 0);
    cyc(5);
    check("u1_left_edge_pulses", npulse[1] - n0, 0);
    check("u1_left_edge_x", int'(x_v[1]), 0);

    // Unit 1: back to x=1, walk right to 291, then saturate at 292.
    rst_v[1] = 1'b1;
    cyc(2);
    push(1, 1'b0, 1);
    rst_v[1] = 1'b0;
    wait_idle(1, "u1_reinit");
    xm = 1;
    for (int i = 0; i < 145; i++) begin
      push(1, 1'b1, xm); push(1, 1'b0, xm + 2);
      tick(1, 1'b0, 1'b1);
      wait_idle(1, "u1_walk");
      xm += 2;
    end
    check("u1_walk_x", int'(x_v[1]), 291);
    n0 = npulse[1];
    push(1, 1'b1, 291); push(1, 1'b0, 292);
    tick(1, 1'b0, 1'b1);
    wait_idle(1, "u1_right_sat");
    check("u1_right_sat_x", int'(x_v[1]), 292);
    check("u1_right_sat_pulses", npulse[1] - n0, 2);
    n0 = npulse[1];
    tick(1, 1'b0, 1'b1);
    check("u1_right_edge_busy", int'(busy_v[1]), 0);
    cyc(5);
    check("u1_right_edge_pulses", npulse[1] - n0, 0);
    tick(1, 1'b1, 1'b1);
    check("u1_both_busy", int'(busy_v[1]), 0);
    cyc(5);
    check("u1_both_pulses", npulse[1] - n0, 0);
    check("u1_both_x", int'(x_v[1]), 292);

    check("u0_sb_empty", gu[0].exp_q.size(), 0);
    check("u1_sb_empty", gu[1].exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
